// File: rtl/sextium_pkg.sv
// sextium_pkg
//   Constants shared between the Sextium control unit and its datapath:
//   opcode numbers, controller state encoding, datapath select encodings,
//   and the bundle of registered control outputs.
package sextium_pkg;

    // Opcodes (4-bit slot values)
    localparam logic [3:0] OP_NOP     = 4'd0;
    localparam logic [3:0] OP_SYSCALL = 4'd1;
    localparam logic [3:0] OP_LOAD    = 4'd2;
    localparam logic [3:0] OP_STORE   = 4'd3;
    localparam logic [3:0] OP_SWAPA   = 4'd4;
    localparam logic [3:0] OP_SWAPD   = 4'd5;
    localparam logic [3:0] OP_BRANCHZ = 4'd6;
    localparam logic [3:0] OP_BRANCHN = 4'd7;
    localparam logic [3:0] OP_JUMP    = 4'd8;
    localparam logic [3:0] OP_CONST   = 4'd9;
    localparam logic [3:0] OP_ADD     = 4'd10;
    localparam logic [3:0] OP_SUB     = 4'd11;
    localparam logic [3:0] OP_MUL     = 4'd12;
    localparam logic [3:0] OP_DIV     = 4'd13;
    localparam logic [3:0] OP_HALT    = 4'd14;

    typedef enum logic [3:0] {
        ST_FETCH, ST_FWAIT, ST_FLATCH, ST_DECODE, ST_MEMWAIT,
        ST_IOWAIT, ST_ALUWAIT, ST_NEXT, ST_HALTED
    } state_t;

    // Datapath select encodings
    localparam logic       SELADDR_PC  = 1'b0;
    localparam logic       SELADDR_AR  = 1'b1;
    localparam logic [1:0] SELACC_MEM  = 2'd0;
    localparam logic [1:0] SELACC_IO   = 2'd1;
    localparam logic [1:0] SELACC_SWAP = 2'd2;
    localparam logic [1:0] SELACC_ALU  = 2'd3;
    localparam logic       SELSWAP_AR  = 1'b0;
    localparam logic       SELSWAP_DR  = 1'b1;
    localparam logic       SELPC1_NEXT = 1'b0;
    localparam logic       SELPC1_REG  = 1'b1;
    localparam logic       SELPC2_AR   = 1'b0;
    localparam logic       SELPC2_ACC  = 1'b1;

    // All registered control outputs except the slot index
    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       pc_write;
        logic       acc_write;
        logic       doswap;
        logic       runio;
        logic       alu_start;
        logic       seladdr;
        logic [1:0] selacc;
        logic       selswap;
        logic       selpc1;
        logic       selpc2;
        logic [1:0] aluinsn;
        logic       halted;
    } ctl_t;

    // ADD..DIV map onto ALU codes 0..3
    function automatic logic [1:0] alu_code(input logic [3:0] op);
        logic [3:0] d;
        d = op - OP_ADD;
        return d[1:0];
    endfunction

endpackage

// File: rtl/seq_controller.sv
// seq_controller
//   Sextium control unit: fetches an instruction word, walks its SLOTS
//   opcode slots in order and drives the datapath strobes/selects. All
//   outputs are registered. Memory accesses wait on mem_ready, DIV (and
//   MUL when MUL_MULTI=1) wait on alu_done, SYSCALL waits on iobusy.
// Ports
//   clock, reset           : clock, synchronous active-low reset
//   insn                   : opcode of slot curinsn
//   accz, accn             : ACC zero / negative flags
//   iobusy, mem_ready,
//   alu_done               : handshakes from IO, memory, multi-cycle ALU
//   mem_read .. runio      : datapath strobes
//   seladdr .. selpc2      : datapath selects
//   curinsn                : current slot index
//   aluinsn, alu_start     : ALU operation and multi-cycle start pulse
//   halted                 : processor stopped until reset
module seq_controller
    import sextium_pkg::*;
#(
    parameter int SLOTS     = 4,
    parameter int SLOT_W    = $clog2(SLOTS),
    parameter int MUL_MULTI = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [3:0]        insn,
    input  logic              accz,
    input  logic              accn,
    input  logic              iobusy,
    input  logic              mem_ready,
    input  logic              alu_done,
    output logic              mem_read,
    output logic              mem_write,
    output logic              ir_write,
    output logic              pc_write,
    output logic              acc_write,
    output logic              doswap,
    output logic              runio,
    output logic              seladdr,
    output logic [1:0]        selacc,
    output logic              selswap,
    output logic              selpc1,
    output logic              selpc2,
    output logic [SLOT_W-1:0] curinsn,
    output logic [1:0]        aluinsn,
    output logic              alu_start,
    output logic              halted
);

    localparam logic MUL_IS_MULTI = (MUL_MULTI != 0);

    state_t            r_state, w_state_nxt;
    ctl_t              r_ctl,   w_ctl_nxt;
    logic [SLOT_W-1:0] r_cur,   w_cur_nxt;
    logic              r_xfer,  w_xfer_nxt;   // control transfer ends the word
    logic [3:0]        r_op,    w_op_nxt;     // opcode held through wait states

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= ST_FETCH;
            r_ctl   <= '0;
            r_cur   <= '0;
            r_xfer  <= 1'b0;
            r_op    <= OP_NOP;
        end else begin
            r_state <= w_state_nxt;
            r_ctl   <= w_ctl_nxt;
            r_cur   <= w_cur_nxt;
            r_xfer  <= w_xfer_nxt;
            r_op    <= w_op_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ctl_nxt   = r_ctl;      // selects, aluinsn and halted hold
        w_cur_nxt   = r_cur;
        w_xfer_nxt  = r_xfer;
        w_op_nxt    = r_op;
        // strobes are single-state unless a state re-asserts them
        w_ctl_nxt.mem_read  = 1'b0;
        w_ctl_nxt.mem_write = 1'b0;
        w_ctl_nxt.ir_write  = 1'b0;
        w_ctl_nxt.pc_write  = 1'b0;
        w_ctl_nxt.acc_write = 1'b0;
        w_ctl_nxt.doswap    = 1'b0;
        w_ctl_nxt.runio     = 1'b0;
        w_ctl_nxt.alu_start = 1'b0;

        case (r_state)
            ST_FETCH: begin
                w_ctl_nxt.mem_read = 1'b1;
                w_ctl_nxt.seladdr  = SELADDR_PC;
                w_cur_nxt          = '0;
                w_state_nxt        = ST_FWAIT;
            end
            ST_FWAIT: begin
                // read held through FLATCH so IR captures stable data
                w_ctl_nxt.mem_read = 1'b1;
                if (mem_ready) begin
                    w_ctl_nxt.ir_write = 1'b1;
                    w_ctl_nxt.pc_write = 1'b1;
                    w_ctl_nxt.selpc1   = SELPC1_NEXT;
                    w_state_nxt        = ST_FLATCH;
                end
            end
            ST_FLATCH: w_state_nxt = ST_DECODE;
            ST_DECODE: begin
                w_op_nxt    = insn;
                w_state_nxt = ST_NEXT;
                case (insn)
                    OP_LOAD, OP_CONST: begin
                        w_ctl_nxt.mem_read = 1'b1;
                        w_ctl_nxt.selacc   = SELACC_MEM;
                        w_ctl_nxt.seladdr  = (insn == OP_LOAD) ? SELADDR_AR : SELADDR_PC;
                        w_state_nxt        = ST_MEMWAIT;
                    end
                    OP_STORE: begin
                        w_ctl_nxt.mem_write = 1'b1;
                        w_ctl_nxt.seladdr   = SELADDR_AR;
                        w_state_nxt         = ST_MEMWAIT;
                    end
                    OP_SWAPA, OP_SWAPD: begin
                        w_ctl_nxt.acc_write = 1'b1;
                        w_ctl_nxt.doswap    = 1'b1;
                        w_ctl_nxt.selacc    = SELACC_SWAP;
                        w_ctl_nxt.selswap   = (insn == OP_SWAPD) ? SELSWAP_DR : SELSWAP_AR;
                    end
                    OP_ADD, OP_SUB, OP_MUL, OP_DIV: begin
                        w_ctl_nxt.aluinsn = alu_code(insn);
                        w_ctl_nxt.selacc  = SELACC_ALU;
                        if (insn == OP_DIV || (insn == OP_MUL && MUL_IS_MULTI)) begin
                            w_ctl_nxt.alu_start = 1'b1;
                            w_state_nxt         = ST_ALUWAIT;
                        end else begin
                            w_ctl_nxt.acc_write = 1'b1;
                        end
                    end
                    OP_SYSCALL: begin
                        w_ctl_nxt.runio  = 1'b1;
                        w_ctl_nxt.selacc = SELACC_IO;
                        w_state_nxt      = ST_IOWAIT;
                    end
                    OP_BRANCHZ, OP_BRANCHN, OP_JUMP: begin
                        if (insn == OP_JUMP || (insn == OP_BRANCHZ && accz) ||
                            (insn == OP_BRANCHN && accn)) begin
                            w_ctl_nxt.pc_write = 1'b1;
                            w_ctl_nxt.selpc1   = SELPC1_REG;
                            w_ctl_nxt.selpc2   = (insn == OP_JUMP) ? SELPC2_ACC : SELPC2_AR;
                            w_xfer_nxt         = 1'b1;
                        end
                    end
                    OP_HALT: begin
                        w_ctl_nxt.halted = 1'b1;
                        w_state_nxt      = ST_HALTED;
                    end
                    default: ;  // NOP and reserved opcode
                endcase
            end
            ST_MEMWAIT: begin
                w_ctl_nxt.mem_read  = r_ctl.mem_read;
                w_ctl_nxt.mem_write = r_ctl.mem_write;
                if (mem_ready) begin
                    // a read stays up one more cycle while ACC/PC capture it
                    w_ctl_nxt.mem_write = 1'b0;
                    w_ctl_nxt.acc_write = (r_op != OP_STORE);
                    if (r_op == OP_CONST) begin
                        w_ctl_nxt.pc_write = 1'b1;
                        w_ctl_nxt.selpc1   = SELPC1_NEXT;
                    end
                    w_state_nxt = ST_NEXT;
                end
            end
            ST_ALUWAIT: begin
                if (alu_done) begin
                    w_ctl_nxt.acc_write = 1'b1;
                    w_state_nxt         = ST_NEXT;
                end
            end
            ST_IOWAIT: begin
                if (iobusy) w_ctl_nxt.runio = 1'b1;
                else        w_state_nxt     = ST_NEXT;
            end
            ST_NEXT: begin
                if (r_xfer || r_cur == SLOT_W'(SLOTS - 1)) begin
                    w_xfer_nxt  = 1'b0;
                    w_cur_nxt   = '0;
                    w_state_nxt = ST_FETCH;
                end else begin
                    w_cur_nxt   = r_cur + 1'b1;
                    w_state_nxt = ST_DECODE;
                end
            end
            ST_HALTED: ;    // absorbing until reset
            default:   w_state_nxt = ST_FETCH;
        endcase
    end

    assign mem_read  = r_ctl.mem_read;
    assign mem_write = r_ctl.mem_write;
    assign ir_write  = r_ctl.ir_write;
    assign pc_write  = r_ctl.pc_write;
    assign acc_write = r_ctl.acc_write;
    assign doswap    = r_ctl.doswap;
    assign runio     = r_ctl.runio;
    assign alu_start = r_ctl.alu_start;
    assign seladdr   = r_ctl.seladdr;
    assign selacc    = r_ctl.selacc;
    assign selswap   = r_ctl.selswap;
    assign selpc1    = r_ctl.selpc1;
    assign selpc2    = r_ctl.selpc2;
    assign aluinsn   = r_ctl.aluinsn;
    assign halted    = r_ctl.halted;
    assign curinsn   = r_cur;

endmodule

// File: tb/tb_seq_controller.sv
// tb_seq_controller
//   Two controllers (SLOTS=4 single-cycle MUL, SLOTS=8 multi-cycle MUL) are
//   exercised one after the other. A cycle-level expectation trace is built
//   from the instruction-level timing rules (per-opcode phase lengths and
//   strobe patterns); the same trace supplies the inputs, including random
//   noise on handshakes in cycles where they must be ignored.
module tb_seq_controller;

    localparam logic [3:0] NOP = 0, SYSCALL = 1, LOAD = 2, STORE = 3, SWAPA = 4,
        SWAPD = 5, BRZ = 6, BRN = 7, JUMP = 8, CONST = 9, ADD = 10, SUB = 11,
        MUL = 12, DIV = 13, HALT = 14;

    localparam logic [7:0] S_MR = 8'h80, S_MW = 8'h40, S_IR = 8'h20, S_PC = 8'h10,
        S_AW = 8'h08, S_SW = 8'h04, S_IO = 8'h02, S_AS = 8'h01;

    typedef struct packed {
        logic mem_read, mem_write, ir_write, pc_write, acc_write, doswap, runio, alu_start;
        logic seladdr; logic [1:0] selacc; logic selswap, selpc1, selpc2;
        logic [1:0] aluinsn; logic halted; logic [2:0] curinsn;
    } obs_t;

    typedef struct packed {
        logic rst_n; logic [3:0] insn; logic accz, accn, iobusy, mem_ready, alu_done; logic chk;
    } in_t;

    typedef struct { in_t i; obs_t e; } ent_t;

    logic clk = 0, rstA = 0, rstB = 0;
    logic [3:0] insn = 0;
    logic accz = 0, accn = 0, iobusy = 0, mem_ready = 0, alu_done = 0;

    always #5 clk = ~clk;

    // DUT A: SLOTS=4, MUL single-cycle
    logic a_mr, a_mw, a_ir, a_pc, a_aw, a_sw, a_rio, a_sa, a_ssw, a_sp1, a_sp2, a_as, a_h;
    logic [1:0] a_sacc, a_alu, a_cur;
    seq_controller #(.SLOTS(4), .MUL_MULTI(0)) uA (
        .clock(clk), .reset(rstA), .insn(insn), .accz(accz), .accn(accn), .iobusy(iobusy),
        .mem_ready(mem_ready), .alu_done(alu_done), .mem_read(a_mr), .mem_write(a_mw),
        .ir_write(a_ir), .pc_write(a_pc), .acc_write(a_aw), .doswap(a_sw), .runio(a_rio),
        .seladdr(a_sa), .selacc(a_sacc), .selswap(a_ssw), .selpc1(a_sp1), .selpc2(a_sp2),
        .curinsn(a_cur), .aluinsn(a_alu), .alu_start(a_as), .halted(a_h));

    // DUT B: SLOTS=8, MUL multi-cycle
    logic b_mr, b_mw, b_ir, b_pc, b_aw, b_sw, b_rio, b_sa, b_ssw, b_sp1, b_sp2, b_as, b_h;
    logic [1:0] b_sacc, b_alu;
    logic [2:0] b_cur;
    seq_controller #(.SLOTS(8), .MUL_MULTI(1)) uB (
        .clock(clk), .reset(rstB), .insn(insn), .accz(accz), .accn(accn), .iobusy(iobusy),
        .mem_ready(mem_ready), .alu_done(alu_done), .mem_read(b_mr), .mem_write(b_mw),
        .ir_write(b_ir), .pc_write(b_pc), .acc_write(b_aw), .doswap(b_sw), .runio(b_rio),
        .seladdr(b_sa), .selacc(b_sacc), .selswap(b_ssw), .selpc1(b_sp1), .selpc2(b_sp2),
        .curinsn(b_cur), .aluinsn(b_alu), .alu_start(b_as), .halted(b_h));

    obs_t actA, actB;
    assign actA = {a_mr, a_mw, a_ir, a_pc, a_aw, a_sw, a_rio, a_as, a_sa, a_sacc, a_ssw,
                   a_sp1, a_sp2, a_alu, a_h, 1'b0, a_cur};
    assign actB = {b_mr, b_mw, b_ir, b_pc, b_aw, b_sw, b_rio, b_as, b_sa, b_sacc, b_ssw,
                   b_sp1, b_sp2, b_alu, b_h, b_cur};

    int checks = 0, errors = 0;
    ent_t q[$];
    obs_t m;                 // persistent expected output state
    int slots_cfg;
    bit mulm_cfg;
    bit stopped;
    int rst_at = -1;
    logic [3:0] wop [8];
    int wwait [8];

    function automatic logic rbit(input int v);
        return (v < 0) ? 1'($urandom_range(0, 1)) : 1'(v);
    endfunction

    task automatic emit(input logic [7:0] stb, input int op, input int mr, input int ad,
                        input int ib, input int az, input int an);
        ent_t e;
        e.i.rst_n = 1'b1;
        e.i.insn = (op < 0) ? 4'($urandom) : 4'(op);
        e.i.mem_ready = rbit(mr);
        e.i.alu_done = rbit(ad);
        e.i.iobusy = rbit(ib);
        e.i.accz = rbit(az);
        e.i.accn = rbit(an);
        e.i.chk = 1'b1;
        e.e = m;
        {e.e.mem_read, e.e.mem_write, e.e.ir_write, e.e.pc_write,
         e.e.acc_write, e.e.doswap, e.e.runio, e.e.alu_start} = stb;
        q.push_back(e);
    endtask

    task automatic e0(input logic [7:0] stb);
        emit(stb, -1, -1, -1, -1, -1, -1);
    endtask

    // Reset cycle: outputs still show pre-reset state; all zero afterwards
    task automatic do_reset(input logic [7:0] stb, input bit chk);
        emit(stb, -1, -1, -1, -1, -1, -1);
        q[q.size()-1].i.rst_n = 1'b0;
        q[q.size()-1].i.chk = chk;
        m = '0;
    endtask

    task automatic fetch(input int w);
        e0(0);                                  // FETCH
        m.seladdr = 1'b0;
        for (int i = 0; i < w; i++) emit(S_MR, -1, 0, -1, -1, -1, -1);
        emit(S_MR, -1, 1, -1, -1, -1, -1);
        m.selpc1 = 1'b0;
        e0(S_MR | S_IR | S_PC);                 // IR/PC latch
    endtask

    task automatic slot(input int s, input logic [3:0] op, input int w, output bit endw);
        bit az, an, xfer;
        az = 1'($urandom_range(0, 1));
        an = 1'($urandom_range(0, 1));
        xfer = 0;
        endw = 0;
        m.curinsn = 3'(s);
        emit(0, int'(op), -1, -1, -1, int'(az), int'(an));   // decode
        case (op)
            LOAD, CONST, STORE: begin
                if (op == STORE) m.seladdr = 1'b1;
                else begin m.selacc = 2'd0; m.seladdr = (op == LOAD); end
                for (int i = 0; i <= w; i++)
                    emit((op == STORE) ? S_MW : S_MR, -1, (i == w) ? 1 : 0, -1, -1, -1, -1);
                if (op == CONST) m.selpc1 = 1'b0;
                if (op == STORE) e0(0);
                else e0(S_MR | S_AW | ((op == CONST) ? S_PC : 8'h00));
            end
            SWAPA, SWAPD: begin
                m.selacc = 2'd2;
                m.selswap = (op == SWAPD);
                e0(S_AW | S_SW);
            end
            ADD, SUB, MUL, DIV: begin
                m.aluinsn = 2'(op - 4'd10);
                m.selacc = 2'd3;
                if (op == DIV || (op == MUL && mulm_cfg))
                    for (int i = 0; i <= w; i++)
                        emit((i == 0) ? S_AS : 8'h00, -1, -1, (i == w) ? 1 : 0, -1, -1, -1);
                e0(S_AW);
            end
            SYSCALL: begin
                m.selacc = 2'd1;
                for (int i = 0; i <= w; i++) begin
                    if (i == rst_at) begin
                        do_reset(S_IO, 1);
                        rst_at = -1;
                        stopped = 1;
                        return;
                    end
                    emit(S_IO, -1, -1, -1, (i < w) ? 1 : 0, -1, -1);
                end
                e0(0);
            end
            BRZ, BRN, JUMP: begin
                if (op == JUMP || (op == BRZ && az) || (op == BRN && an)) begin
                    m.selpc1 = 1'b1;
                    m.selpc2 = (op == JUMP);
                    e0(S_PC);
                    xfer = 1;
                end else e0(0);
            end
            HALT: begin
                m.halted = 1'b1;
                repeat (6) e0(0);
                do_reset(0, 1);
                stopped = 1;
                return;
            end
            default: e0(0);
        endcase
        endw = xfer || (s == slots_cfg - 1);
        if (endw) m.curinsn = 3'd0;
    endtask

    task automatic word(input int wf);
        bit endw;
        stopped = 0;
        fetch(wf);
        for (int s = 0; s < slots_cfg; s++) begin
            slot(s, wop[s], wwait[s], endw);
            if (stopped || endw) return;
        end
    endtask

    task automatic set_word(input logic [3:0] o0, o1, o2, o3, o4, o5, o6, o7, input int w0);
        wop = '{o0, o1, o2, o3, o4, o5, o6, o7};
        wwait = '{w0, 0, 0, 0, 0, 0, 0, 0};
    endtask

    task automatic rand_words(input int n);
        for (int k = 0; k < n; k++) begin
            for (int s = 0; s < 8; s++) begin
                wop[s] = 4'($urandom_range(0, 15));
                if (wop[s] == HALT && $urandom_range(0, 3) != 0) wop[s] = NOP;
                wwait[s] = (wop[s] == DIV || wop[s] == MUL) ? $urandom_range(0, 6)
                                                            : $urandom_range(0, 3);
            end
            word($urandom_range(0, 2));
        end
    endtask

    // Model-side counters used to pin the trace against hand-derived numbers
    function automatic int cnt(input int from, input int sel);
        int c = 0;
        for (int k = from; k < q.size(); k++)
            case (sel)
                0: c += int'(q[k].e.mem_read);
                1: c += int'(q[k].e.acc_write);
                2: c += int'(q[k].e.pc_write);
                3: c += int'(q[k].e.runio);
                4: c += int'(q[k].e.halted);
                default: c += int'(q[k].e.alu_start);
            endcase
        return c;
    endfunction

    task automatic pin(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL model %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic run_queue(input bit useB);
        obs_t act;
        for (int k = 0; k < q.size(); k++) begin
            @(posedge clk);
            #1;
            insn = q[k].i.insn; accz = q[k].i.accz; accn = q[k].i.accn;
            iobusy = q[k].i.iobusy; mem_ready = q[k].i.mem_ready; alu_done = q[k].i.alu_done;
            rstA = useB ? 1'b0 : q[k].i.rst_n;
            rstB = useB ? q[k].i.rst_n : 1'b0;
            @(negedge clk);
            act = useB ? actB : actA;
            if (q[k].i.chk) begin
                checks++;
                if (act !== q[k].e) begin
                    errors++;
                    $display("FAIL outputs dut%s cycle %0d: got %h, expected %h",
                             useB ? "B" : "A", k, act, q[k].e);
                end
            end
        end
        q.delete();
    endtask

    initial begin
        int q0;
        // ---------------- DUT A: SLOTS=4 ----------------
        slots_cfg = 4; mulm_cfg = 0; m = '0;
        do_reset(0, 0);
        do_reset(0, 1);                                  // reset state is all zero

        q0 = q.size(); set_word(ADD, SUB, NOP, NOP, NOP, NOP, NOP, NOP, 0); word(0);
        pin("addsub_len", q.size() - q0, 11);
        pin("addsub_accw", cnt(q0, 1), 2);

        q0 = q.size(); set_word(LOAD, NOP, NOP, NOP, NOP, NOP, NOP, NOP, 3); word(0);
        pin("load_len", q.size() - q0, 15);
        pin("load_memrd", cnt(q0, 0), 7);
        pin("load_accw", cnt(q0, 1), 1);

        q0 = q.size(); set_word(NOP, JUMP, LOAD, LOAD, NOP, NOP, NOP, NOP, 0); word(0);
        pin("jump_len", q.size() - q0, 7);
        pin("jump_pcw", cnt(q0, 2), 2);

        q0 = q.size(); set_word(DIV, NOP, NOP, NOP, NOP, NOP, NOP, NOP, 7); word(1);
        pin("div_len", q.size() - q0, 20);
        pin("div_accw", cnt(q0, 1), 1);
        pin("div_start", cnt(q0, 5), 1);

        q0 = q.size(); set_word(SYSCALL, NOP, NOP, NOP, NOP, NOP, NOP, NOP, 4); word(0);
        pin("sys_runio", cnt(q0, 3), 5);

        rst_at = 2; set_word(SYSCALL, NOP, NOP, NOP, NOP, NOP, NOP, NOP, 4); word(0);
        set_word(CONST, STORE, SWAPD, BRZ, NOP, NOP, NOP, NOP, 2); word(0);
        rand_words(40);
        run_queue(0);

        // ---------------- DUT B: SLOTS=8, multi-cycle MUL ----------------
        slots_cfg = 8; mulm_cfg = 1; m = '0;
        do_reset(0, 1);
        q0 = q.size(); set_word(NOP, ADD, NOP, LOAD, NOP, HALT, ADD, ADD, 0); word(0);
        pin("halt_len", q.size() - q0, 22);
        pin("halt_cnt", cnt(q0, 4), 7);
        set_word(MUL, SWAPA, BRN, NOP, NOP, NOP, NOP, NOP, 2); word(0);
        rand_words(40);
        run_queue(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_controller.md
# seq_controller

Parametrised successor to the Sextium III control unit: a registered-output FSM that fetches an instruction word, decodes its opcode slots in order, and drives the existing datapath (PC, IR, ACC, AR/DR swap, ALU, IO). Compared with the first generation it adds a configurable slot count, a `mem_ready` wait-state handshake on every memory access, an `alu_done` handshake for multi-cycle DIV/MUL in place of a fixed delay, and a HALT opcode.

## Interface
- `SLOTS`, 4: opcodes per instruction word; power of two, ≥2.
- `SLOT_W`, $clog2(SLOTS): width of `curinsn`.
- `MUL_MULTI`, 0: 1 makes MUL use the `alu_done` handshake like DIV.

Ports:
- `clock` in 1: single clock, all state on posedge.
- `reset` in 1: synchronous, active-low; all state cleared on a posedge with `reset`=0.
- `insn` in 4: opcode of slot `curinsn`, selected by the datapath.
- `accz`, `accn` in 1: ACC zero / ACC negative.
- `iobusy` in 1: IO unit busy.
- `mem_ready` in 1: memory completes the access held by `mem_read`/`mem_write`; data stays valid while `mem_read` remains high.
- `alu_done` in 1: multi-cycle ALU result valid.
- `mem_read`, `mem_write`, `ir_write`, `pc_write`, `acc_write`, `doswap`, `runio` out 1: strobes.
- `seladdr` out 1 (0 PC, 1 AR); `selacc` out 2 (0 MEM, 1 IO, 2 SWAP, 3 ALU); `selswap` out 1 (0 AR, 1 DR); `selpc1` out 1 (0 next, 1 reg); `selpc2` out 1 (0 AR, 1 ACC).
- `curinsn` out SLOT_W: current slot index.
- `aluinsn` out 2: 0 ADD, 1 SUB, 2 MUL, 3 DIV.
- `alu_start` out 1: one-cycle start pulse for a multi-cycle op.
- `halted` out 1: processor stopped.

## Operation
- Opcodes 0–13 as in the existing ISA (NOP, SYSCALL, LOAD, STORE, SWAPA, SWAPD, BRANCHZ, BRANCHN, JUMP, CONST, ADD, SUB, MUL, DIV); 14 HALT; 15 reserved, executes as NOP.
- States: FETCH, FWAIT, FLATCH, DECODE, MEMWAIT, IOWAIT, ALUWAIT, NEXT, HALTED.
- FETCH: `mem_read`=1, `seladdr`=PC, `curinsn`=0 → FWAIT.
- FWAIT: hold; on `mem_ready`: `ir_write`=1, `pc_write`=1, `selpc1`=next → FLATCH.
- FLATCH: clear all strobes → DECODE.
- DECODE, by opcode:
  - LOAD / CONST: `mem_read`, `selacc`=MEM, `seladdr`=AR or PC → MEMWAIT.
  - STORE: `mem_write`, `seladdr`=AR → MEMWAIT.
  - MEMWAIT: on `mem_ready`: `acc_write` (plus `pc_write` next for CONST), or nothing extra for STORE → NEXT.
  - SWAPA / SWAPD: `acc_write`, `doswap`, `selacc`=SWAP → NEXT.
  - ADD / SUB / single-cycle MUL: `aluinsn`, `selacc`=ALU, `acc_write` → NEXT.
  - DIV / multi MUL: `alu_start` one cycle → ALUWAIT; on `alu_done`: `acc_write` → NEXT.
  - SYSCALL: `runio`=1, `selacc`=IO → IOWAIT; when `iobusy`=0: `runio`=0 → NEXT.
  - BRANCHZ / BRANCHN taken, or JUMP: `pc_write`, `selpc1`=reg, `selpc2`=AR/ACC, transfer flag set → NEXT. Not taken → NEXT.
  - HALT → HALTED.
- NEXT: clear all strobes.
  - If the transfer flag is set or `curinsn`==SLOTS-1: clear the flag, `curinsn`=0 → FETCH.
  - Otherwise `curinsn`+1 → DECODE.
- HALTED: absorbing; `halted`=1, all strobes 0, exited only by reset.

## Timing
- All outputs registered. Every output resets to 0, including `curinsn`, `aluinsn` and all selects; state resets to FETCH.
- Reset mid-operation (any wait state) abandons the access; `runio`, `alu_start` and all strobes are 0 on the following cycle.
- Fetch with `mem_ready` tied 1: 3 cycles. Each extra cycle `mem_ready` stays low adds 1.
- Register-only ops: 2 cycles (DECODE, NEXT). LOAD/STORE/CONST: 3 cycles plus wait cycles.
- `alu_done` is sampled only in ALUWAIT; if it is high in the cycle after `alu_start`, the op costs 3 cycles.
- Write strobes are high for exactly one cycle per access.
- `mem_read` stays high from request until the cycle after `mem_ready`.
- `mem_ready` or `alu_done` high outside their wait states is ignored.

## Structure
- Shared package `sextium_pkg`: opcode constants (including HALT), state enum, and the SELADDR/SELACC/SELSWAP/SELPC encodings, shared with the datapath.
- No sub-module; a single FSM with the slot counter inline.

## Test plan
- SLOTS=4, `mem_ready`=1, word {ADD,SUB,NOP,NOP} → `acc_write` pulses in slots 0 and 1; `curinsn` 0→1→2→3; new fetch after slot 3.
- LOAD with `mem_ready` low for 3 cycles → `mem_read` high 5 cycles; single `acc_write` on the cycle after `mem_ready`.
- JUMP in slot 1 → `pc_write` with `selpc1`=1, `selpc2`=1; slots 2–3 skipped; FETCH with `curinsn`=0.
- DIV with `alu_done` arriving 7 cycles after `alu_start` → exactly one `acc_write`; `aluinsn`=3 throughout.
- SYSCALL with `iobusy` high 4 cycles → `runio` high until `iobusy` falls; reset asserted during IOWAIT in a second run → all outputs 0 next cycle.
- SLOTS=8, HALT in slot 5 → `halted`=1 and stays; no strobes until reset.
